caesar_clk_gate_ctrl: RTL



---
 rtl/caesar_clk_gate_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/caesar_clk_gate_ctrl.sv
// Automatic clock-gate controller for Caesar: gates after programmable idle time, wakes on demand.
// Optional gated-cycle statistics counter enabled by defining CAESAR_CG_STATS_EN.
module caesar_clk_gate_ctrl #(
    parameter int unsigned IDLE_CNT_W  = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [IDLE_CNT_W-1:0] idle_thr_i,
    input  logic                  busy_i,
    input  logic                  req_i,
`ifdef CAESAR_CG_STATS_EN
    input  logic                  stats_clr_i,
    output logic [31:0]           gated_cycles_o,
`endif
    output logic                  req_ready_o,
    output logic                  clk_en_o,
    output logic                  gated_o
);

    localparam int unsigned WakeMax = (WAKE_CYCLES == 0) ? 1 : WAKE_CYCLES;
    localparam int unsigned WakeW   = $clog2(WakeMax + 1);
    localparam logic [WakeW:0] WakeLast = (WakeW + 1)'(WakeMax);

    typedef enum logic [1:0] {
        StRun,
        StIdle,
        StGated,
        StWake
    } state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic [IDLE_CNT_W-1:0] w_idle_cnt_d;
    logic [WakeW-1:0]      r_wake_cnt;
    logic [WakeW-1:0]      w_wake_cnt_d;
    logic                  r_clk_en;

    logic [IDLE_CNT_W:0]   w_idle_inc;
    logic [IDLE_CNT_W-1:0] w_thr_eff;
    logic [WakeW:0]        w_wake_inc;
    logic                  w_wake_evt;

    // One extra bit so the compare cannot overflow at the maximum threshold.
    assign w_idle_inc = {1'b0, r_idle_cnt} + (IDLE_CNT_W + 1)'(1);
    assign w_thr_eff  = (idle_thr_i == '0) ? IDLE_CNT_W'(1) : idle_thr_i;
    assign w_wake_inc = {1'b0, r_wake_cnt} + (WakeW + 1)'(1);
    assign w_wake_evt = busy_i || req_i || !enable_i;

    always_comb begin
        w_state_d    = r_state;
        w_idle_cnt_d = r_idle_cnt;
        w_wake_cnt_d = r_wake_cnt;
        unique case (r_state)
            StRun: begin
                if (!w_wake_evt) begin
                    w_state_d    = StIdle;
                    w_idle_cnt_d = '0;
                end
            end
            StIdle: begin
                // Activity wins over gating so a last-cycle request keeps the clock on.
                if (w_wake_evt) begin
                    w_state_d    = StRun;
                    w_idle_cnt_d = '0;
                end else if (w_idle_inc >= {1'b0, w_thr_eff}) begin
                    w_state_d    = StGated;
                    w_idle_cnt_d = '0;
                end else begin
                    w_idle_cnt_d = w_idle_inc[IDLE_CNT_W-1:0];
                end
            end
            StGated: begin
                if (w_wake_evt) begin
                    w_state_d    = StWake;
                    w_wake_cnt_d = '0;
                end
            end
            StWake: begin
                if (w_wake_inc >= WakeLast) begin
                    w_state_d    = StRun;
                    w_wake_cnt_d = '0;
                end else begin
                    w_wake_cnt_d = w_wake_inc[WakeW-1:0];
                end
            end
            default: begin
                w_state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StRun;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_clk_en   <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_idle_cnt <= w_idle_cnt_d;
            r_wake_cnt <= w_wake_cnt_d;
            r_clk_en   <= (w_state_d != StGated);
        end
    end

    assign req_ready_o = (r_state == StRun) || (r_state == StIdle);
    assign gated_o     = (r_state == StGated);
    assign clk_en_o    = r_clk_en;

`ifdef CAESAR_CG_STATS_EN
    logic [31:0] r_gated_cycles;

    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr_i) begin
            r_gated_cycles <= '0;
        end else if ((r_state == StGated) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
            r_gated_cycles <= r_gated_cycles + 32'd1;
        end
    end

    assign gated_cycles_o = r_gated_cycles;
`endif

endmodule
